regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, giving the maximum beats per locked burst (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 presents a write beat.
REQ-005 SHALL have port req0_addr, input, 3 bits: requester 0 target register.
REQ-006 SHALL have port req0_data, input, 16 bits: requester 0 write data.
REQ-007 SHALL have port req0_lock, input, 1 bit: requester 0 asks to keep ownership after this beat.
REQ-008 SHALL have port req0_ready, output, 1 bit: requester 0 beat accepted this cycle when valid is also high.
REQ-009 SHALL have ports req1_valid, req1_addr, req1_data, req1_lock and req1_ready, identical to REQ-004..008 for requester 1.
REQ-010 SHALL have port rf_we, output, 1 bit: register-file write enable.
REQ-011 SHALL have port rf_addre_wr, output, 3 bits: register-file write address.
REQ-012 SHALL have port rf_D, output, 16 bits: register-file write data.
REQ-013 SHALL have port lock_owner, output, 2 bits: 00 none, 01 requester 0, 10 requester 1.

Function
REQ-014 SHALL accept at most one beat per cycle; a beat is accepted when reqN_valid and reqN_ready are both high.
REQ-015 SHALL drive reqN_ready combinationally from current state and valids; ready SHALL NOT be high for both requesters in the same cycle.
REQ-016 SHALL use FSM states IDLE, OWN0 and OWN1, plus a last_served bit and a 4-bit burst counter.
REQ-017 IDLE: if exactly one valid, SHALL grant that requester; if both valid, SHALL grant the requester other than last_served; if none, no grant.
REQ-018 IDLE: an accepted beat with lock=0 SHALL set last_served to the winner and stay in IDLE.
REQ-019 IDLE: an accepted beat with lock=1 and MAX_BURST>1 SHALL go to OWNx for winner x and load the burst counter with 1.
REQ-020 OWNx: SHALL grant only requester x; the other ready SHALL stay 0 regardless of its valid.
REQ-021 OWNx: each accepted beat SHALL increment the burst counter.
REQ-022 OWNx: SHALL return to IDLE and set last_served=x when any of these occurs: an accepted beat has lock=0; an accepted beat brings the counter to MAX_BURST; or reqx_valid is low for a cycle.
REQ-023 OWNx: a beat accepted on the exit cycle SHALL still be written.
REQ-024 rf_we, rf_addre_wr and rf_D SHALL be registered: one cycle after acceptance, rf_we=1 with that beat's addr/data; otherwise rf_we=0.
REQ-025 When rf_we=0, rf_addre_wr and rf_D SHALL hold their last values.
REQ-026 Accepted-beat-to-rf_we latency SHALL be exactly 1 cycle; back-to-back accepted beats SHALL produce back-to-back rf_we pulses.
REQ-027 lock_owner SHALL reflect the current FSM state (IDLE=00, OWN0=01, OWN1=10).
REQ-028 Same-address writes from both requesters SHALL be serialized in grant order; the later write wins in the register file.
REQ-029 Address 0 SHALL be treated like any other address.
REQ-030 With MAX_BURST=1, lock SHALL be ignored and the FSM SHALL never leave IDLE.

Reset
REQ-031 With rst_n=0 at a clk edge, the block SHALL enter IDLE, set last_served=1 (requester 0 wins the first contention), clear the burst counter, and drive rf_we=0, rf_addre_wr=0, rf_D=0 and lock_owner=00.
REQ-032 While rst_n=0, both readys SHALL be 0.
REQ-033 A reset during OWNx SHALL abort the burst; a beat accepted in the cycle before reset SHALL NOT be written.

Verification
REQ-034 Scenario: after reset, both valid, lock=0, req0 (addr 1, data 10) and req1 (addr 3, data 8) -> req0 accepted first; rf_we writes 1/10, then 3/8 on consecutive cycles.
REQ-035 Scenario: both valid continuously for 6 beats, lock=0 -> grants alternate 0,1,0,1,0,1 and rf_we stays high for 6 cycles.
REQ-036 Scenario: req1 sends lock=1 for 6 beats while req0 is valid, MAX_BURST=4 -> req1 gets 4 consecutive beats with lock_owner=10, then req0 is granted and lock_owner=00.
REQ-037 Scenario: req0 is in OWN0 after 2 beats and drops valid for one cycle -> returns to IDLE; a pending req1 is granted on the next cycle.
REQ-038 Scenario: rst_n low for one cycle mid-burst in OWN1 -> next cycle lock_owner=00, rf_we=0, and the beat accepted before reset is never written.
REQ-039 Scenario: both requesters write addr 5 (data 0x1111 and 0x2222) in the same cycle -> two rf_we pulses on addr 5; the final value follows grant order.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter in front of an 8 x 16 register file.
// Round-robin on contention, with optional locked bursts of up to MAX_BURST beats.
module regfile_wr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [2:0]  req0_addr,
    input  logic [15:0] req0_data,
    input  logic        req0_lock,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_addr,
    input  logic [15:0] req1_data,
    input  logic        req1_lock,
    output logic        req1_ready,
    output logic        rf_we,
    output logic [2:0]  rf_addre_wr,
    output logic [15:0] rf_D,
    output logic [1:0]  lock_owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    localparam bit         LOCK_EN     = (MAX_BURST > 1);

    state_t      state;
    logic        last_served;
    logic [3:0]  burst_cnt;
    logic [3:0]  burst_next;
    logic        rf_we_q;

    logic        grant0;
    logic        grant1;
    logic        accept0;
    logic        accept1;
    logic        accepted;
    logic [2:0]  win_addr;
    logic [15:0] win_data;
    logic        win_lock;
    logic        own_valid;
    logic        own_is1;

    // On contention in IDLE the requester that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
                        grant0 = last_served;
                        grant1 = !last_served;
                    end else begin
                        grant0 = req0_valid;
                        grant1 = req1_valid;
                    end
                end
                OWN0:    grant0 = req0_valid;
                OWN1:    grant1 = req1_valid;
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept0    = req0_valid && grant0;
    assign accept1    = req1_valid && grant1;
    assign accepted   = accept0 || accept1;
    assign win_addr   = accept1 ? req1_addr : req0_addr;
    assign win_data   = accept1 ? req1_data : req0_data;
    assign win_lock   = accept1 ? req1_lock : req0_lock;
    assign own_is1    = (state == OWN1);
    assign own_valid  = own_is1 ? req1_valid : req0_valid;
    assign burst_next = burst_cnt + 4'd1;

    // A write still sitting in the output register when reset arrives is dropped.
    assign rf_we = rf_we_q && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            burst_cnt   <= 4'd0;
            rf_we_q     <= 1'b0;
            rf_addre_wr <= 3'd0;
            rf_D        <= 16'd0;
            lock_owner  <= 2'b00;
        end else begin
            rf_we_q <= accepted;
            if (accepted) begin
                rf_addre_wr <= win_addr;
                rf_D        <= win_data;
            end

            case (state)
                IDLE: begin
                    if (accepted) begin
                        if (win_lock && LOCK_EN) begin
                            state      <= accept1 ? OWN1 : OWN0;
                            lock_owner <= accept1 ? 2'b10 : 2'b01;
                            burst_cnt  <= 4'd1;
                        end else begin
                            last_served <= accept1;
                        end
                    end
                end
                OWN0, OWN1: begin
                    // The owner leaves on an unlock, a full burst, or an idle cycle.
                    if (!own_valid ||
                        (accepted && (!win_lock || burst_next == BURST_LIMIT))) begin
                        state       <= IDLE;
                        lock_owner  <= 2'b00;
                        last_served <= own_is1;
                        burst_cnt   <= 4'd0;
                    end else if (accepted) begin
                        burst_cnt <= burst_next;
                    end
                end
                default: begin
                    state      <= IDLE;
                    lock_owner <= 2'b00;
                    burst_cnt  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected writes queue up when a grant is expected
// and are matched against rf_we/rf_addre_wr/rf_D on the following cycle.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_lock, req0_ready;
    logic [2:0]  req0_addr;
    logic [15:0] req0_data;
    logic        req1_valid, req1_lock, req1_ready;
    logic [2:0]  req1_addr;
    logic [15:0] req1_data;
    logic        rf_we;
    logic [2:0]  rf_addre_wr;
    logic [15:0] rf_D;
    logic [1:0]  lock_owner;

    logic        nb_req0_ready, nb_req1_ready, nb_rf_we;
    logic [2:0]  nb_rf_addre_wr;
    logic [15:0] nb_rf_D;
    logic [1:0]  nb_lock_owner;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [2:0]  last_addr;
    logic [15:0] last_data;
    logic [15:0] shadow_rf [8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_lock(req0_lock), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_lock(req1_lock), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_addre_wr(rf_addre_wr), .rf_D(rf_D), .lock_owner(lock_owner)
    );

    // Single-beat variant sees the same traffic and must never lock.
    regfile_wr_arbiter #(.MAX_BURST(1)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_lock(req0_lock), .req0_ready(nb_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_lock(req1_lock), .req1_ready(nb_req1_ready),
        .rf_we(nb_rf_we), .rf_addre_wr(nb_rf_addre_wr), .rf_D(nb_rf_D),
        .lock_owner(nb_lock_owner)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input logic exp_r0, input logic exp_r1, input logic [1:0] exp_own);
        beat_t b;
        check("req0_ready", {15'd0, req0_ready}, {15'd0, exp_r0});
        check("req1_ready", {15'd0, req1_ready}, {15'd0, exp_r1});
        check("lock_owner", {14'd0, lock_owner}, {14'd0, exp_own});
        check("nb_lock_owner", {14'd0, nb_lock_owner}, 16'd0);
        if (!rst_n) begin
            check("rf_we_in_reset", {15'd0, rf_we}, 16'd0);
            exp_q.delete();
            last_addr = 3'd0;
            last_data = 16'd0;
        end else if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("rf_we_write", {15'd0, rf_we}, 16'd1);
            check("rf_addre_wr", {13'd0, rf_addre_wr}, {13'd0, b.addr});
            check("rf_D", rf_D, b.data);
            last_addr = b.addr;
            last_data = b.data;
        end else begin
            check("rf_we_idle", {15'd0, rf_we}, 16'd0);
            check("rf_addre_wr_hold", {13'd0, rf_addre_wr}, {13'd0, last_addr});
            check("rf_D_hold", rf_D, last_data);
        end
        if (rf_we === 1'b1) shadow_rf[rf_addre_wr] = rf_D;
    endtask

    task automatic applyStimulus(
        input logic rst, input logic v0, input logic [2:0] a0, input logic [15:0] d0, input logic l0,
        input logic v1, input logic [2:0] a1, input logic [15:0] d1, input logic l1,
        input logic er0, input logic er1, input logic [1:0] eown);
        beat_t b;
        @(negedge clk);
        rst_n      = rst;
        req0_valid = v0; req0_addr = a0; req0_data = d0; req0_lock = l0;
        req1_valid = v1; req1_addr = a1; req1_data = d1; req1_lock = l1;
        #1;
        checkOutput(er0, er1, eown);
        if (rst) begin
            if (er0 && v0) begin
                b = {a0, d0};
                exp_q.push_back(b);
            end else if (er1 && v1) begin
                b = {a1, d1};
                exp_q.push_back(b);
            end
        end
    endtask

    initial begin
        int n0;
        int n1;
        $display("[TB] regfile_wr_arbiter directed run");
        for (int k = 0; k < 8; k++) shadow_rf[k] = 16'd0;
        last_addr = 3'd0;
        last_data = 16'd0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = 3'd0; req0_data = 16'd0; req0_lock = 1'b0;
        req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 16'd0; req1_lock = 1'b0;
        repeat (2) @(posedge clk);

        // Held reset: readys stay low even with both valid, outputs cleared.
        applyStimulus(0, 1, 3'd1, 16'd10, 0, 1, 3'd3, 16'd8, 0, 0, 0, 2'b00);
        check("rst_addr", {13'd0, rf_addre_wr}, 16'd0);
        check("rst_data", rf_D, 16'd0);

        // First contention goes to requester 0, then requester 1.
        applyStimulus(1, 1, 3'd1, 16'd10, 0, 1, 3'd3, 16'd8, 0, 1, 0, 2'b00);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 1, 3'd3, 16'd8, 0, 0, 1, 2'b00);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 0, 3'd0, 16'd0, 0, 0, 0, 2'b00);

        // Continuous contention alternates grants with back-to-back writes.
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 3'd2, 16'(16'h0100 + n0), 0, 1, 3'd4, 16'(16'h0200 + n1), 0,
                          (i % 2) == 0, (i % 2) == 1, 2'b00);
            if ((i % 2) == 0) n0++;
            else n1++;
        end
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 0, 3'd0, 16'd0, 0, 0, 0, 2'b00);

        // Requester 1 locks: four beats max, then requester 0 gets in.
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 1, 3'd6, 16'h3000, 1, 0, 1, 2'b00);
        for (int k = 1; k <= 3; k++)
            applyStimulus(1, 1, 3'd7, 16'h0777, 0, 1, 3'd6, 16'(16'h3000 + k), 1, 0, 1, 2'b10);
        applyStimulus(1, 1, 3'd7, 16'h0777, 0, 1, 3'd6, 16'h3004, 1, 1, 0, 2'b00);
        applyStimulus(1, 1, 3'd7, 16'h0778, 0, 1, 3'd6, 16'h3004, 1, 0, 1, 2'b00);
        applyStimulus(1, 1, 3'd7, 16'h0778, 0, 0, 3'd0, 16'd0, 0, 0, 0, 2'b10);
        applyStimulus(1, 1, 3'd7, 16'h0778, 0, 0, 3'd0, 16'd0, 0, 1, 0, 2'b00);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 0, 3'd0, 16'd0, 0, 0, 0, 2'b00);

        // Requester 0 owns, drops valid for a cycle, pending requester 1 follows.
        applyStimulus(1, 1, 3'd2, 16'h4001, 1, 0, 3'd0, 16'd0, 0, 1, 0, 2'b00);
        applyStimulus(1, 1, 3'd2, 16'h4002, 1, 1, 3'd3, 16'h5001, 0, 1, 0, 2'b01);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 1, 3'd3, 16'h5001, 0, 0, 0, 2'b01);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 1, 3'd3, 16'h5001, 0, 0, 1, 2'b00);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 0, 3'd0, 16'd0, 0, 0, 0, 2'b00);

        // Reset mid-burst in OWN1: the last accepted beat (0x6003) must not land.
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 1, 3'd1, 16'h6001, 1, 0, 1, 2'b00);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 1, 3'd1, 16'h6002, 1, 0, 1, 2'b10);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 1, 3'd1, 16'h6003, 1, 0, 1, 2'b10);
        applyStimulus(0, 1, 3'd5, 16'h1111, 0, 1, 3'd5, 16'h2222, 0, 0, 0, 2'b10);

        // Same-address collision after reset, then a write to address 0.
        applyStimulus(1, 1, 3'd5, 16'h1111, 0, 1, 3'd5, 16'h2222, 0, 1, 0, 2'b00);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 1, 3'd5, 16'h2222, 0, 0, 1, 2'b00);
        applyStimulus(1, 1, 3'd0, 16'hBEEF, 0, 0, 3'd0, 16'd0, 0, 1, 0, 2'b00);
        applyStimulus(1, 0, 3'd0, 16'd0, 0, 0, 3'd0, 16'd0, 0, 0, 0, 2'b00);

        check("final_rf5", shadow_rf[5], 16'h2222);
        check("final_rf0", shadow_rf[0], 16'hBEEF);
        check("final_rf1", shadow_rf[1], 16'h6002);
        check("final_rf4", shadow_rf[4], 16'h0202);
        check("final_rf6", shadow_rf[6], 16'h3004);
        check("final_rf3", shadow_rf[3], 16'h5001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
